// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle between the Memory stage and the data memory
interface data_mem_if;
   logic        i_valid_dmem;
   logic        o_ready_dmem;
   logic [31:0] i_addr;
   logic        i_we;
   logic [2:0]  i_func3;
   logic [31:0] i_wr_data;
   logic [31:0] o_read_data;
   logic        o_ack;
   logic        o_err;
   modport master (
      output i_valid_dmem, i_addr, i_we, i_func3, i_wr_data,
      input  o_ready_dmem, o_read_data, o_ack, o_err
   );
   modport slave (
      input  i_valid_dmem, i_addr, i_we, i_func3, i_wr_data,
      output o_ready_dmem, o_read_data, o_ack, o_err
   );
endinterface

// File: rtl/data_mem.sv
// data_mem: single-port data memory with valid/ready request, fixed-latency ack, store lane placement and alignment checks
module data_mem #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY = 1
) (
   input logic       clk,
   input logic       rst_n,
   data_mem_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  ready_q, ack_q, err_q, err_pend_q;
   logic [31:0]           rdata_q;
   logic [31:0]           mem_q [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] idx_d;
   logic                  accept_d, is_b_d, is_h_d, is_w_d, f3_ok_d, misal_d, err_d, wr_d;
   logic [3:0]            strb_d;
   logic [31:0]           wdata_d;
   logic                  unused_addr;
   assign unused_addr = ^bus.i_addr[31:ADDR_WIDTH+2];
   // decode the request: legality, alignment, byte strobes and lane-replicated store data
   always_comb begin
      accept_d = rst_n && bus.i_valid_dmem && ready_q;
      idx_d = bus.i_addr[ADDR_WIDTH+1:2];
      is_b_d = bus.i_func3[1:0] == 2'b00;
      is_h_d = bus.i_func3[1:0] == 2'b01;
      is_w_d = bus.i_func3[1:0] == 2'b10;
      f3_ok_d = bus.i_we ? (!bus.i_func3[2] && bus.i_func3[1:0] != 2'b11)
                         : (bus.i_func3[1:0] != 2'b11 && bus.i_func3[2:1] != 2'b11);
      misal_d = (is_h_d && bus.i_addr[0]) || (is_w_d && bus.i_addr[1:0] != 2'b00);
      err_d = !f3_ok_d || misal_d;
      wr_d = accept_d && bus.i_we && !err_d;
      strb_d = is_b_d ? 4'b0001 << bus.i_addr[1:0] : is_h_d ? 4'b0011 << bus.i_addr[1:0] : 4'b1111;
      wdata_d = is_b_d ? {4{bus.i_wr_data[7:0]}} : is_h_d ? {2{bus.i_wr_data[15:0]}} : bus.i_wr_data;
   end
   // request FSM: capture on accept, count out the latency, pulse the response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         err_pend_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= !accept_d;
               if (accept_d) begin
                  rdata_q    <= mem_q[idx_d];
                  err_pend_q <= err_d;
                  cnt_q      <= CNT_LOAD;
                  state_q    <= (LATENCY > 1) ? WAIT : RESP;
                  ack_q      <= (LATENCY == 1);
                  err_q      <= (LATENCY == 1) && err_d;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd0) begin
                  state_q <= RESP;
                  ack_q   <= 1'b1;
                  err_q   <= err_pend_q;
               end
            end
            RESP: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   // commit strobed lanes of a legal store on its accept edge; array is never reset
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (wr_d && strb_d[b]) mem_q[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
   end
   assign bus.o_ready_dmem = ready_q;
   assign bus.o_read_data  = rdata_q;
   assign bus.o_ack        = ack_q;
   assign bus.o_err        = err_q;
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed vectors against a LATENCY=1 and a LATENCY=3 instance
module tb_data_mem;
   logic        clk = 1'b0;
   logic        rst1_n, rst3_n;
   int          total = 0, bad = 0;
   logic [1:0]  valid, we, ready, ack, err;
   logic [2:0]  f3 [2];
   logic [31:0] addr [2], wd [2], rdat [2];
   data_mem_if b1();
   data_mem_if b3();
   data_mem #(.ADDR_WIDTH(10), .LATENCY(1)) u1 (.clk(clk), .rst_n(rst1_n), .bus(b1));
   data_mem #(.ADDR_WIDTH(10), .LATENCY(3)) u3 (.clk(clk), .rst_n(rst3_n), .bus(b3));
   assign b1.i_valid_dmem = valid[0];
   assign b1.i_we         = we[0];
   assign b1.i_func3      = f3[0];
   assign b1.i_addr       = addr[0];
   assign b1.i_wr_data    = wd[0];
   assign b3.i_valid_dmem = valid[1];
   assign b3.i_we         = we[1];
   assign b3.i_func3      = f3[1];
   assign b3.i_addr       = addr[1];
   assign b3.i_wr_data    = wd[1];
   assign ready = {b3.o_ready_dmem, b1.o_ready_dmem};
   assign ack   = {b3.o_ack, b1.o_ack};
   assign err   = {b3.o_err, b1.o_err};
   assign rdat[0] = b1.o_read_data;
   assign rdat[1] = b3.o_read_data;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        chk_rd;
      logic [31:0] rd;
      logic        err;
   } vec_t;
   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // one request on port p; returns response data/err and cycles from accept to ack
   task automatic req(input int p, input vec_t v, output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      valid[p] = 1'b1;
      we[p]    = v.we;
      f3[p]    = v.f3;
      addr[p]  = v.addr;
      wd[p]    = v.wd;
      chk($sformatf("p%0d_ready_before", p), 32'(ready[p]), 32'd1);
      @(negedge clk);
      valid[p] = 1'b0;
      we[p]    = 1'b0;
      addr[p]  = 32'hDEAD_BEE0;
      wd[p]    = 32'h5A5A_5A5A;
      lat = 1;
      while (!ack[p] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = rdat[p];
      er = err[p];
      @(negedge clk);
      chk($sformatf("p%0d_ack_pulse", p), 32'(ack[p]), 32'd0);
      chk($sformatf("p%0d_ready_after", p), 32'(ready[p]), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      vt.push_back('{1'b1, 3'b010, 32'h14,   32'h1234_5678, 1'b0, 32'h0,         1'b0});
      vt.push_back('{1'b0, 3'b010, 32'h14,   32'h0,         1'b1, 32'h1234_5678, 1'b0});
      vt.push_back('{1'b1, 3'b010, 32'h20,   32'h0,         1'b0, 32'h0,         1'b0});
      vt.push_back('{1'b1, 3'b000, 32'h22,   32'h0000_00AB, 1'b1, 32'h0,         1'b0});
      vt.push_back('{1'b1, 3'b001, 32'h20,   32'h0000_BEEF, 1'b1, 32'h00AB_0000, 1'b0});
      vt.push_back('{1'b0, 3'b010, 32'h20,   32'h0,         1'b1, 32'h00AB_BEEF, 1'b0});
      vt.push_back('{1'b1, 3'b010, 32'h21,   32'hFFFF_FFFF, 1'b1, 32'h00AB_BEEF, 1'b1});
      vt.push_back('{1'b0, 3'b010, 32'h20,   32'h0,         1'b1, 32'h00AB_BEEF, 1'b0});
      vt.push_back('{1'b0, 3'b001, 32'h23,   32'h0,         1'b1, 32'h00AB_BEEF, 1'b1});
      vt.push_back('{1'b0, 3'b000, 32'h23,   32'h0,         1'b1, 32'h00AB_BEEF, 1'b0});
      vt.push_back('{1'b1, 3'b010, 32'h1000, 32'hCAFE_0001, 1'b0, 32'h0,         1'b0});
      vt.push_back('{1'b0, 3'b010, 32'h0,    32'h0,         1'b1, 32'hCAFE_0001, 1'b0});
      vt.push_back('{1'b0, 3'b100, 32'h21,   32'h0,         1'b1, 32'h00AB_BEEF, 1'b0});
      vt.push_back('{1'b0, 3'b011, 32'h20,   32'h0,         1'b1, 32'h00AB_BEEF, 1'b1});
      vt.push_back('{1'b0, 3'b110, 32'h20,   32'h0,         1'b1, 32'h00AB_BEEF, 1'b1});
      vt.push_back('{1'b1, 3'b011, 32'h20,   32'h1111_1111, 1'b1, 32'h00AB_BEEF, 1'b1});
      vt.push_back('{1'b1, 3'b100, 32'h20,   32'h2222_2222, 1'b1, 32'h00AB_BEEF, 1'b1});
      vt.push_back('{1'b1, 3'b001, 32'h21,   32'h0000_1234, 1'b1, 32'h00AB_BEEF, 1'b1});
      vt.push_back('{1'b0, 3'b010, 32'h20,   32'h0,         1'b1, 32'h00AB_BEEF, 1'b0});
      vt.push_back('{1'b0, 3'b101, 32'h22,   32'h0,         1'b1, 32'h00AB_BEEF, 1'b0});
      vt.push_back('{1'b1, 3'b001, 32'h22,   32'h0000_5566, 1'b1, 32'h00AB_BEEF, 1'b0});
      vt.push_back('{1'b0, 3'b010, 32'h20,   32'h0,         1'b1, 32'h5566_BEEF, 1'b0});
      vt.push_back('{1'b1, 3'b010, 32'h16,   32'h7777_7777, 1'b0, 32'h0,         1'b1});
      vt.push_back('{1'b0, 3'b010, 32'h14,   32'h0,         1'b1, 32'h1234_5678, 1'b0});
      valid = '0;
      we    = '0;
      for (int p = 0; p < 2; p++) begin
         f3[p]   = 3'b000;
         addr[p] = 32'h0;
         wd[p]   = 32'h0;
      end
      rst1_n = 1'b0;
      rst3_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("p%0d_rst_ready", p), 32'(ready[p]), 32'd0);
         chk($sformatf("p%0d_rst_ack", p), 32'(ack[p]), 32'd0);
         chk($sformatf("p%0d_rst_err", p), 32'(err[p]), 32'd0);
         chk($sformatf("p%0d_rst_rdata", p), rdat[p], 32'd0);
      end
      rst1_n = 1'b1;
      rst3_n = 1'b1;
      @(negedge clk);
      for (int p = 0; p < 2; p++) chk($sformatf("p%0d_ready_release", p), 32'(ready[p]), 32'd1);
      for (int i = 0; i < vt.size(); i++) begin
         req(0, vt[i], rd, er, lat);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'd1);
         chk($sformatf("v%0d_err", i), 32'(er), 32'(vt[i].err));
         if (vt[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
      end
      repeat (3) @(negedge clk);
      chk("l1_rdata_hold", rdat[0], 32'h1234_5678);
      req(1, '{1'b1, 3'b010, 32'h40, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0}, rd, er, lat);
      chk("l3_sw_lat", 32'(lat), 32'd3);
      chk("l3_sw_err", 32'(er), 32'd0);
      req(1, '{1'b1, 3'b010, 32'h42, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1}, rd, er, lat);
      chk("l3_misal_lat", 32'(lat), 32'd3);
      chk("l3_misal_err", 32'(er), 32'd1);
      @(negedge clk);
      valid[1] = 1'b1;
      we[1]    = 1'b0;
      f3[1]    = 3'b010;
      addr[1]  = 32'h40;
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("stream_ack_k%0d", k), 32'(ack[1]), 32'(k % 4 == 3));
         chk($sformatf("stream_ready_k%0d", k), 32'(ready[1]), 32'(k % 4 == 0));
         if (k % 4 == 3) begin
            chk($sformatf("stream_rdata_k%0d", k), rdat[1], 32'h0BAD_F00D);
            chk($sformatf("stream_err_k%0d", k), 32'(err[1]), 32'd0);
         end
      end
      valid[1] = 1'b0;
      @(negedge clk);
      valid[1] = 1'b1;
      addr[1]  = 32'h40;
      @(negedge clk);
      valid[1] = 1'b0;
      chk("midrst_busy", 32'(ready[1]), 32'd0);
      rst3_n = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 32'(ready[1]), 32'd0);
      chk("midrst_ack", 32'(ack[1]), 32'd0);
      chk("midrst_err", 32'(err[1]), 32'd0);
      chk("midrst_rdata", rdat[1], 32'd0);
      rst3_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("midrst_noack_%0d", k), 32'(ack[1]), 32'd0);
         chk($sformatf("midrst_ready_%0d", k), 32'(ready[1]), 32'd1);
      end
      req(1, '{1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0}, rd, er, lat);
      chk("post_rst_lat", 32'(lat), 32'd3);
      chk("post_rst_err", 32'(er), 32'd0);
      chk("post_rst_rdata", rd, 32'h0BAD_F00D);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
